// File: rtl/dmem_responder.sv
// Data-memory responder for the core load/store port: byte/half/word loads and stores with wait states.
// Latency: WAIT_CYCLES+1 cycles from the request acceptance edge to rsp_valid.
// Backpressure: one request in flight, req_ready low until the response is taken; response held while rsp_ready is low.
module dmem_responder #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_f3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               latch_req;
  logic               do_access;

  logic               we_q;
  logic [2:0]         f3_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;

  logic [31:0]        rdata_q;
  logic               err_q;

  logic [31:0]        mem [DEPTH_WORDS];

  logic [31:0]        word_idx;
  logic [1:0]         lane;
  logic [IDX_W-1:0]   mem_idx;
  logic [31:0]        cur_word;

  logic               acc_err;
  logic [31:0]        acc_rdata;
  logic [31:0]        acc_wword;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;

  // Address split of the latched request; the range check uses the full word index.
  assign word_idx = 32'(addr_q[ADDR_W-1:2]);
  assign lane     = addr_q[1:0];
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign cur_word = mem[mem_idx];

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Access datapath: load extraction/extension, store lane merge and error detection.
  always_comb begin
    acc_err   = 1'b0;
    acc_rdata = 32'h0;
    acc_wword = cur_word;
    byte_sel  = cur_word[{lane, 3'b000} +: 8];
    half_sel  = addr_q[1] ? cur_word[31:16] : cur_word[15:0];
    if (we_q) begin
      case (f3_q)
        3'b000: acc_wword[{lane, 3'b000} +: 8] = wdata_q[7:0];
        3'b001: begin
          if (addr_q[0])      acc_err = 1'b1;
          else if (addr_q[1]) acc_wword[31:16] = wdata_q[15:0];
          else                acc_wword[15:0]  = wdata_q[15:0];
        end
        3'b010: begin
          if (lane != 2'b00) acc_err = 1'b1;
          else               acc_wword = wdata_q;
        end
        default: acc_err = 1'b1;
      endcase
    end else begin
      case (f3_q)
        3'b000: acc_rdata = {{24{byte_sel[7]}}, byte_sel};
        3'b100: acc_rdata = {24'h0, byte_sel};
        3'b001: begin
          if (addr_q[0]) acc_err = 1'b1;
          acc_rdata = {{16{half_sel[15]}}, half_sel};
        end
        3'b101: begin
          if (addr_q[0]) acc_err = 1'b1;
          acc_rdata = {16'h0, half_sel};
        end
        3'b010: begin
          if (lane != 2'b00) acc_err = 1'b1;
          acc_rdata = cur_word;
        end
        default: acc_err = 1'b1;
      endcase
    end
    if (word_idx >= DEPTH_WORDS) acc_err = 1'b1;
    // Stores and rejected requests always return zero data.
    if (acc_err || we_q) acc_rdata = 32'h0;
  end

  // Next-state and handshake outputs of the IDLE/WAIT/RESP sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    latch_req = 1'b0;
    do_access = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          latch_req = 1'b1;
          cnt_d     = 4'(WAIT_CYCLES);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          do_access = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and the registered response; the response only changes at the access edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (do_access) begin
        rdata_q <= acc_rdata;
        err_q   <= acc_err;
      end
    end
  end

  // Request capture at the acceptance edge; no reset needed since it is only consumed after capture.
  always_ff @(posedge clk) begin
    if (latch_req) begin
      we_q    <= req_we;
      f3_q    <= req_f3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Storage write at the WAIT->RESP edge; a reset on that edge cancels the commit.
  always_ff @(posedge clk) begin
    if (rst_n && do_access && we_q && !acc_err) mem[mem_idx] <= acc_wword;
  end

endmodule
